// File: rtl/facache_arb.sv
`default_nettype none
// ============================================================================
// Module      : facache_arb
// Description : Arbiter in front of a small fully-associative cache. Serves
//               two read ports and one insert port, one cache operation in
//               flight at a time, with round-robin between the readers and a
//               bounded insert streak while reads are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module facache_arb #(
    parameter int STREAK_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // read requesters
    input  logic        r0_req,
    input  logic [15:0] r0_adr,
    output logic        r0_gnt,
    input  logic        r1_req,
    input  logic [15:0] r1_adr,
    output logic        r1_gnt,
    // insert requester
    input  logic        ins_req,
    input  logic [15:0] ins_adr,
    input  logic [15:0] ins_data,
    output logic        ins_gnt,
    // read responses
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_hit,
    output logic [15:0] rsp_data,
    // forwarded evictions
    output logic        ev_valid,
    output logic [15:0] ev_adr,
    output logic [15:0] ev_data,
    // cache side
    output logic [15:0] c_adr,
    output logic        c_read_en,
    output logic [15:0] c_ins_adr,
    output logic [15:0] c_ins_data,
    output logic        c_ins_valid,
    input  logic [15:0] c_data_out,
    input  logic        c_valid_out,
    input  logic [15:0] c_ev_adr,
    input  logic [15:0] c_ev_data,
    input  logic        c_ev_valid,
    output logic        busy
);

    localparam logic [2:0] c_STREAK_MAX = 3'(STREAK_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_WAIT  = 3'd2,
        INS      = 3'd3,
        INS_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_rd_pend;
    logic        w_rd_gnt;
    logic        r_rr;        // 0: r0 preferred, 1: r1 preferred
    logic [2:0]  r_streak;    // inserts granted back-to-back over waiting reads
    logic [15:0] r_rd_adr;
    logic        r_rd_id;
    logic [15:0] r_ins_adr;
    logic [15:0] r_ins_data;

    assign w_rd_pend = r0_req | r1_req;
    assign w_rd_gnt  = r0_gnt | r1_gnt;
    assign busy      = (r_state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next state and cache strobes; grants are held off while
    // reset is asserted so nothing is offered during reset.
    always_comb begin
        w_state_nxt = r_state;
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        ins_gnt     = 1'b0;
        c_read_en   = 1'b0;
        c_adr       = 16'h0000;
        c_ins_valid = 1'b0;
        c_ins_adr   = 16'h0000;
        c_ins_data  = 16'h0000;
        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    if (ins_req && (!w_rd_pend || (r_streak < c_STREAK_MAX))) begin
                        ins_gnt     = 1'b1;
                        w_state_nxt = INS;
                    end else if (r0_req && (!r1_req || !r_rr)) begin
                        r0_gnt      = 1'b1;
                        w_state_nxt = RD;
                    end else if (r1_req) begin
                        r1_gnt      = 1'b1;
                        w_state_nxt = RD;
                    end
                end
            end
            RD: begin
                c_read_en   = 1'b1;
                c_adr       = r_rd_adr;
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                w_state_nxt = IDLE;
            end
            INS: begin
                c_ins_valid = 1'b1;
                c_ins_adr   = r_ins_adr;
                c_ins_data  = r_ins_data;
                w_state_nxt = INS_WAIT;
            end
            INS_WAIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latching plus round-robin pointer and insert-streak bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= 1'b0;
            r_streak   <= 3'd0;
            r_rd_adr   <= 16'h0000;
            r_rd_id    <= 1'b0;
            r_ins_adr  <= 16'h0000;
            r_ins_data <= 16'h0000;
        end else begin
            if (ins_gnt) begin
                r_ins_adr  <= ins_adr;
                r_ins_data <= ins_data;
                if (w_rd_pend) begin
                    r_streak <= (r_streak == c_STREAK_MAX) ? r_streak : r_streak + 3'd1;
                end else begin
                    r_streak <= 3'd0;
                end
            end
            if (w_rd_gnt) begin
                r_rd_adr <= r1_gnt ? r1_adr : r0_adr;
                r_rd_id  <= r1_gnt;
                // prefer the reader that was not just served
                r_rr     <= ~r1_gnt;
                r_streak <= 3'd0;
            end
        end
    end

    // Single-cycle response and eviction pulses captured at the end of the wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_data  <= 16'h0000;
            ev_valid  <= 1'b0;
            ev_adr    <= 16'h0000;
            ev_data   <= 16'h0000;
        end else begin
            rsp_valid <= 1'b0;
            ev_valid  <= 1'b0;
            if (r_state == RD_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_id    <= r_rd_id;
                rsp_hit   <= c_valid_out;
                rsp_data  <= c_valid_out ? c_data_out : 16'h0000;
            end
            if ((r_state == INS_WAIT) && c_ev_valid) begin
                ev_valid <= 1'b1;
                ev_adr   <= c_ev_adr;
                ev_data  <= c_ev_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/facache_arb.md
FACACHE_ARB -- requirements
Module: facache_arb

Interface
REQ-001 SHALL have parameter STREAK_MAX, default 3: max consecutive insert grants while any read is pending (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports r0_req/r1_req  input  1 each  read requests; r0_adr/r1_adr  input  16 each  read addresses.
REQ-005 SHALL have ports r0_gnt/r1_gnt  output  1 each  read accepted this cycle.
REQ-006 SHALL have ports ins_req  input  1; ins_adr  input  16; ins_data  input  16; ins_gnt  output  1  insert accepted this cycle.
REQ-007 SHALL have ports rsp_valid  output  1; rsp_id  output  1 (0=r0, 1=r1); rsp_hit  output  1; rsp_data  output  16.
REQ-008 SHALL have ports ev_valid  output  1; ev_adr  output  16; ev_data  output  16  forwarded evictions.
REQ-009 SHALL have cache-side ports c_adr  output  16; c_read_en  output  1; c_ins_adr  output  16; c_ins_data  output  16; c_ins_valid  output  1.
REQ-010 SHALL have cache-side ports c_data_out  input  16; c_valid_out  input  1; c_ev_adr  input  16; c_ev_data  input  16; c_ev_valid  input  1.
REQ-011 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL implement states IDLE, RD, RD_WAIT, INS, INS_WAIT; one cache operation in flight at a time.
REQ-013 SHALL assert grants combinationally only in IDLE, at most one grant per cycle; a request is accepted at a posedge where req && gnt.
REQ-014 Arbitration in IDLE SHALL be: insert wins if ins_req and (no read pending or streak < STREAK_MAX); otherwise a read wins.
REQ-015 Between r0 and r1 SHALL be round-robin: rr pointer names preferred requester, toggles to the other after each read grant; sole requester always wins.
REQ-016 streak SHALL increment (saturating at STREAK_MAX) on insert grant with a read pending, clear on any read grant, clear on insert grant with no read pending.
REQ-017 On read accept SHALL latch address and id, go to RD; in RD drive c_read_en=1, c_adr=latched, c_ins_valid=0; next state RD_WAIT.
REQ-018 In RD_WAIT SHALL sample c_valid_out/c_data_out; next posedge loads rsp_valid=1, rsp_hit=c_valid_out, rsp_data=c_data_out (0 on miss), rsp_id; return to IDLE.
REQ-019 rsp_valid SHALL be a single-cycle pulse, high in the third cycle after the accept edge; no backpressure on responses.
REQ-020 On insert accept SHALL latch adr/data, go to INS; in INS drive c_ins_valid=1 for exactly one cycle, c_read_en=0; next state INS_WAIT.
REQ-021 In INS_WAIT SHALL sample c_ev_valid/c_ev_adr/c_ev_data; if c_ev_valid, next posedge pulses ev_valid=1 one cycle with captured adr/data; return to IDLE.
REQ-022 c_read_en and c_ins_valid SHALL never be high in the same cycle; both 0 in IDLE, RD_WAIT, INS_WAIT.
REQ-023 Insert of an address already cached SHALL complete normally (cache ignores it; ev_valid stays 0).
REQ-024 Requesters SHALL hold req and payload stable until granted; dropping req before grant withdraws it without side effect.
REQ-025 Sustained throughput SHALL be one operation per 3 cycles (accept, issue, sample).

Reset
REQ-026 On rst_n low SHALL immediately force state IDLE, rr=0, streak=0, all gnt/rsp/ev/c_* control outputs 0, data outputs 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no rsp_valid/ev_valid; cache contents are not cleared (cache has no reset).
REQ-028 First active posedge after rst_n rises SHALL be able to grant.

Verification
REQ-029 Insert 0x0010/0xAAAA, then r0 read 0x0010 -> rsp_valid=1, rsp_id=0, rsp_hit=1, rsp_data=0xAAAA, 3rd cycle after accept.
REQ-030 r1 read 0x0099 on empty cache -> rsp_hit=0, rsp_data=0, ev_valid never asserted.
REQ-031 Five distinct inserts 0x1..0x5 with no reads -> 5th insert gives ev_valid pulse, ev_adr=0x0001 with its data.
REQ-032 r0_req and r1_req held high for 4 grants -> grant order r0,r1,r0,r1; each rsp_id matches.
REQ-033 ins_req and r0_req held high continuously -> grants ins,ins,ins,r0,ins... (STREAK_MAX=3).
REQ-034 rst_n low during RD_WAIT -> busy=0 immediately, no rsp_valid; subsequent read still served.
